solver_job_scheduler: RTL and testbench
=======================================

// Module: solver_job_scheduler
// PURPOSE
// - Shares one Solver instance (encrypter + decrypter) between an encrypt requester and a decrypt requester.
// - Holds the selected operand stable for LATENCY cycles, captures the Solver output, and returns a tagged result.
// - Uses valid/ready handshakes on both request channels and on the result channel.
// - Sits between the system front-end and Solver; the Solver is instantiated one level up.
// PARAMETERS
// - RAW_W    60  plaintext width (Solver data_1_80 / output_2_80)
// - ENC_W    78  ciphertext width (Solver data_2_96 / output_1_96)
// - LATENCY  2   cycles operand is held before capture; legal range >=1, 1..255
// - CNT_W    16  width of completed-job counter
// PORTS
// - Clk          in   1      rising-edge clock
// - Rst_n        in   1      asynchronous, active-low reset
// - enc_valid    in   1      encrypt request valid
// - enc_ready    out  1      encrypt request accepted this cycle
// - enc_data     in   RAW_W  plaintext to encrypt
// - dec_valid    in   1      decrypt request valid
// - dec_ready    out  1      decrypt request accepted this cycle
// - dec_data     in   ENC_W  ciphertext to decrypt
// - sol_raw      out  RAW_W  to Solver data_1_80 (registered)
// - sol_enc      out  ENC_W  to Solver data_2_96 (registered)
// - sol_enc_out  in   ENC_W  from Solver output_1_96
// - sol_raw_out  in   RAW_W  from Solver output_2_80
// - res_valid    out  1      result available
// - res_ready    in   1      consumer accepts result
// - res_is_dec   out  1      1 = decrypt result, 0 = encrypt result
// - res_data     out  ENC_W  result; decrypt results are zero-extended from RAW_W
// - busy         out  1      state != IDLE
// - jobs_done    out  CNT_W  count of delivered results; wraps at 2^CNT_W
// BEHAVIOUR
// - Reset (Rst_n=0, async)
//   - All registered outputs go to 0; state = IDLE; rr_ptr = ENC.
//   - Any in-flight job is dropped silently and never delivered.
// - FSM states: IDLE -> WAIT -> DONE -> IDLE.
// - IDLE
//   - grant = rr_ptr channel if that channel is valid, else the other channel if valid, else none.
//   - enc_ready = (state==IDLE) && grant==ENC; dec_ready likewise. Ready is combinational; at most one is high per cycle.
//   - On a handshake:
//     - Load the operand into sol_raw (encrypt) or sol_enc (decrypt); the unselected Solver input is forced to 0.
//     - Latch the op tag, set cnt = LATENCY-1, and go to WAIT.
// - WAIT
//   - Operands are held constant.
//   - cnt != 0: decrement. cnt == 0: capture res_data and res_is_dec, then go to DONE.
//   - Encrypt captures sol_enc_out; decrypt captures {18'b0, sol_raw_out}.
// - DONE
//   - res_valid = 1; res_data and res_is_dec are held stable until the handshake.
//   - On res_valid & res_ready: go to IDLE, increment jobs_done, set rr_ptr = opposite of the op just served, clear sol_raw/sol_enc.
// - Latency: handshake in cycle T -> res_valid high from cycle T+LATENCY+1.
// - Minimum issue interval: LATENCY+2 cycles when res_ready is held high.
// - Simultaneous requests: both valid in IDLE -> rr_ptr wins; the loser stays pending (valid held) and is served next.
// - Requesters must keep valid/data stable until ready. The block never accepts during WAIT or DONE.
// - Backpressure: res_ready low stalls in DONE indefinitely; both request readies stay 0.
// STRUCTURE
// - Shared package solver_pkg:
//   - RAW_W/ENC_W constants.
//   - State encoding (IDLE=2'd0, WAIT=2'd1, DONE=2'd2).
//   - Op tag (OP_ENC=1'b0, OP_DEC=1'b1).
// - Sub-module solver_rr_arb: 2-way round-robin grant logic (valid[1:0], rr_ptr -> grant_onehot[1:0]); purely combinational.
// - Top holds the FSM, hold counter, operand/result registers and jobs_done.
// TESTING
// - Single encrypt, LATENCY=2, res_ready=1:
//   - Stimulus: enc_data=60'h0123456789ABCDE, accepted at T.
//   - Response: res_valid at T+3, res_is_dec=0, res_data = Solver output for that input, jobs_done=1.
// - Single decrypt round-trip:
//   - Stimulus: feed the previous ciphertext on dec_data.
//   - Response: res_is_dec=1, res_data[59:0]=60'h0123456789ABCDE, res_data[77:60]=0.
// - Both valid from reset:
//   - Stimulus: enc and dec requests asserted together.
//   - Response: ENC granted first, DEC second; then both re-asserted -> ENC again (pointer flipped after DEC).
// - Backpressure:
//   - Stimulus: res_ready=0 for 10 cycles after res_valid.
//   - Response: res_data stable, enc_ready=dec_ready=0 throughout, exactly one result on release.
// - Reset mid-WAIT:
//   - Stimulus: Rst_n low one cycle after a handshake.
//   - Response: outputs 0 immediately, no result delivered, jobs_done=0, next request served normally.
// - Counter wrap (CNT_W=2):
//   - Stimulus: 5 jobs.
//   - Response: jobs_done sequence 1,2,3,0,1.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared constants and enums for the solver job scheduler and its arbiter.
// Widths track the Solver's plaintext/ciphertext buses.
package solver_pkg;

    localparam int RAW_W = 60;
    localparam int ENC_W = 78;
    localparam int PAD_W = ENC_W - RAW_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic {
        OP_ENC = 1'b0,
        OP_DEC = 1'b1
    } op_e;

endpackage

// File: rtl/solver_rr_arb.sv
// Two-way round-robin grant: the pointed-to channel wins if valid, else the other one.
// Bit 0 is the encrypt channel, bit 1 the decrypt channel.
module solver_rr_arb
    import solver_pkg::*;
(
    input  logic [1:0] valid_i,
    input  op_e        rr_ptr_i,
    output logic [1:0] grant_onehot_o
);

    always_comb begin
        grant_onehot_o = 2'b00;
        unique case (rr_ptr_i)
            OP_ENC: begin
                if (valid_i[0])      grant_onehot_o = 2'b01;
                else if (valid_i[1]) grant_onehot_o = 2'b10;
            end
            OP_DEC: begin
                if (valid_i[1])      grant_onehot_o = 2'b10;
                else if (valid_i[0]) grant_onehot_o = 2'b01;
            end
            default: grant_onehot_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/solver_job_scheduler.sv
// Time-shares one Solver between encrypt and decrypt requesters: arbitrate, hold the
// operand for LATENCY cycles, capture the Solver output and hand back a tagged result.
module solver_job_scheduler
    import solver_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 16
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             enc_valid,
    output logic             enc_ready,
    input  logic [RAW_W-1:0] enc_data,
    input  logic             dec_valid,
    output logic             dec_ready,
    input  logic [ENC_W-1:0] dec_data,
    output logic [RAW_W-1:0] sol_raw,
    output logic [ENC_W-1:0] sol_enc,
    input  logic [ENC_W-1:0] sol_enc_out,
    input  logic [RAW_W-1:0] sol_raw_out,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_is_dec,
    output logic [ENC_W-1:0] res_data,
    output logic             busy,
    output logic [CNT_W-1:0] jobs_done
);

    localparam logic [7:0] HOLD_INIT = 8'(LATENCY - 1);

    state_e           state_q, state_d;
    op_e              rr_ptr_q, rr_ptr_d;
    op_e              op_q, op_d;
    logic [7:0]       cnt_q, cnt_d;
    logic [RAW_W-1:0] sol_raw_q, sol_raw_d;
    logic [ENC_W-1:0] sol_enc_q, sol_enc_d;
    logic [ENC_W-1:0] res_data_q, res_data_d;
    logic             res_is_dec_q, res_is_dec_d;
    logic [CNT_W-1:0] jobs_done_q, jobs_done_d;
    logic [1:0]       grant;

    solver_rr_arb u_arb (
        .valid_i        ({dec_valid, enc_valid}),
        .rr_ptr_i       (rr_ptr_q),
        .grant_onehot_o (grant)
    );

    always_comb begin
        // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        op_d         = op_q;
        cnt_d        = cnt_q;
        sol_raw_d    = sol_raw_q;
        sol_enc_d    = sol_enc_q;
        res_data_d   = res_data_q;
        res_is_dec_d = res_is_dec_q;
        jobs_done_d  = jobs_done_q;
        enc_ready    = 1'b0;
        dec_ready    = 1'b0;
        res_valid    = 1'b0;

        unique case (state_q)
            IDLE: begin
                enc_ready = grant[0];
                dec_ready = grant[1];
                if (enc_ready && enc_valid) begin
                    sol_raw_d = enc_data;
                    sol_enc_d = '0;
                    op_d      = OP_ENC;
                    cnt_d     = HOLD_INIT;
                    state_d   = WAIT;
                end else if (dec_ready && dec_valid) begin
                    sol_raw_d = '0;
                    sol_enc_d = dec_data;
                    op_d      = OP_DEC;
                    cnt_d     = HOLD_INIT;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    res_data_d   = (op_q == OP_ENC) ? sol_enc_out : {{PAD_W{1'b0}}, sol_raw_out};
                    res_is_dec_d = (op_q == OP_DEC);
                    state_d      = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d     = IDLE;
                    jobs_done_d = jobs_done_q + CNT_W'(1);
                    rr_ptr_d    = (op_q == OP_ENC) ? OP_DEC : OP_ENC;
                    sol_raw_d   = '0;
                    sol_enc_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= OP_ENC;
            op_q         <= OP_ENC;
            cnt_q        <= '0;
            sol_raw_q    <= '0;
            sol_enc_q    <= '0;
            res_data_q   <= '0;
            res_is_dec_q <= 1'b0;
            jobs_done_q  <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            op_q         <= op_d;
            cnt_q        <= cnt_d;
            sol_raw_q    <= sol_raw_d;
            sol_enc_q    <= sol_enc_d;
            res_data_q   <= res_data_d;
            res_is_dec_q <= res_is_dec_d;
            jobs_done_q  <= jobs_done_d;
        end
    end

    assign sol_raw    = sol_raw_q;
    assign sol_enc    = sol_enc_q;
    assign res_data   = res_data_q;
    assign res_is_dec = res_is_dec_q;
    assign busy       = (state_q != IDLE);
    assign jobs_done  = jobs_done_q;

endmodule

// File: tb/tb_solver_job_scheduler.sv
// Self-checking bench: randomized jobs against a transaction-level model of the scheduler,
// with an invertible stand-in Solver and a second narrow-counter instance for wrap checks.
module tb_solver_job_scheduler;
    import solver_pkg::*;

    localparam int LAT = 2;

    localparam logic [RAW_W-1:0] KEY_LO = 60'hF0E1D2C3B4A5968;
    localparam logic [PAD_W-1:0] KEY_HI = 18'h2B3C5;

    logic Clk = 1'b0;
    logic Rst_n;
    always #5 Clk = ~Clk;

    logic             enc_valid, dec_valid, res_ready;
    logic [RAW_W-1:0] enc_data;
    logic [ENC_W-1:0] dec_data;

    logic             enc_ready, dec_ready, res_valid, res_is_dec, busy;
    logic [RAW_W-1:0] sol_raw, sol_raw_out;
    logic [ENC_W-1:0] sol_enc, sol_enc_out, res_data;
    logic [15:0]      jobs_done;

    logic             b_enc_ready, b_dec_ready, b_res_valid, b_res_is_dec, b_busy;
    logic [RAW_W-1:0] b_sol_raw, b_sol_raw_out;
    logic [ENC_W-1:0] b_sol_enc, b_sol_enc_out, b_res_data;
    logic [1:0]       b_jobs_done;

    int checks = 0;
    int errors = 0;
    int m_jobs = 0;
    bit m_ptr  = 1'b0;   // 0: encrypt has priority, 1: decrypt has priority

    bit               s_ok, s_gd, s_both, s_dec;
    int               s_lat;
    logic [ENC_W-1:0] s_data;
    logic [ENC_W-1:0] last_cipher;

    // Stand-in Solver: ciphertext carries plaintext ^ key plus a redundant high part.
    function automatic logic [ENC_W-1:0] solver_encrypt(input logic [RAW_W-1:0] x);
        return {x[PAD_W-1:0] ^ KEY_HI, x ^ KEY_LO};
    endfunction

    function automatic logic [RAW_W-1:0] solver_decrypt(input logic [ENC_W-1:0] y);
        return y[RAW_W-1:0] ^ KEY_LO;
    endfunction

    function automatic bit model_pick_dec(input bit ptr, input bit ev, input bit dv);
        return ptr ? dv : !ev;
    endfunction

    function automatic logic [ENC_W-1:0] model_result(input bit is_dec, input logic [RAW_W-1:0] e,
                                                       input logic [ENC_W-1:0] d);
        logic [ENC_W-1:0] r;
        r = is_dec ? ENC_W'(solver_decrypt(d)) : solver_encrypt(e);
        return r;
    endfunction

    assign sol_enc_out   = solver_encrypt(sol_raw);
    assign sol_raw_out   = solver_decrypt(sol_enc);
    assign b_sol_enc_out = solver_encrypt(b_sol_raw);
    assign b_sol_raw_out = solver_decrypt(b_sol_enc);

    solver_job_scheduler #(.LATENCY(LAT), .CNT_W(16)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .enc_valid(enc_valid), .enc_ready(enc_ready), .enc_data(enc_data),
        .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
        .sol_raw(sol_raw), .sol_enc(sol_enc), .sol_enc_out(sol_enc_out), .sol_raw_out(sol_raw_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_is_dec(res_is_dec), .res_data(res_data),
        .busy(busy), .jobs_done(jobs_done)
    );

    solver_job_scheduler #(.LATENCY(LAT), .CNT_W(2)) dut_wrap (
        .Clk(Clk), .Rst_n(Rst_n),
        .enc_valid(enc_valid), .enc_ready(b_enc_ready), .enc_data(enc_data),
        .dec_valid(dec_valid), .dec_ready(b_dec_ready), .dec_data(dec_data),
        .sol_raw(b_sol_raw), .sol_enc(b_sol_enc), .sol_enc_out(b_sol_enc_out), .sol_raw_out(b_sol_raw_out),
        .res_valid(b_res_valid), .res_ready(res_ready), .res_is_dec(b_res_is_dec), .res_data(b_res_data),
        .busy(b_busy), .jobs_done(b_jobs_done)
    );

    task automatic apply_reset();
        Rst_n     = 1'b0;
        enc_valid = 1'b0;
        dec_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge Clk); #1;
        Rst_n  = 1'b1;
        m_jobs = 0;
        m_ptr  = 1'b0;
    endtask

    // Serves one job with whatever valids the caller raised; returns observations only.
    task automatic serve_one(output bit ok, output bit got_dec, output bit both_rdy, output int lat,
                             output logic [ENC_W-1:0] rdata, output bit rdec);
        int k;
        ok = 1'b1; got_dec = 1'b0; both_rdy = 1'b0; lat = 0; rdata = '0; rdec = 1'b0;
        res_ready = 1'b1;
        k = 0;
        #1;
        while (!(enc_ready || dec_ready) && k < 20) begin
            @(posedge Clk); #2;
            k++;
        end
        if (!(enc_ready || dec_ready)) begin
            ok = 1'b0;
            return;
        end
        both_rdy = enc_ready && dec_ready;
        got_dec  = dec_ready;
        @(posedge Clk); #1;
        if (got_dec) dec_valid = 1'b0;
        else         enc_valid = 1'b0;
        lat = 1;
        while (!res_valid && lat < 20) begin
            @(posedge Clk); #1;
            lat++;
        end
        if (!res_valid) begin
            ok = 1'b0;
            return;
        end
        rdata = res_data;
        rdec  = res_is_dec;
        @(posedge Clk); #1;
    endtask

    task automatic test_reset();
        Rst_n = 1'b0; enc_valid = 1'b0; dec_valid = 1'b0; res_ready = 1'b1;
        enc_data = '0; dec_data = '0;
        #3;
        checks++;
        if ({res_valid, busy, enc_ready, dec_ready, res_is_dec} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got valid=%b busy=%b er=%b dr=%b dec=%b, want all 0",
                     res_valid, busy, enc_ready, dec_ready, res_is_dec);
        end
        checks++;
        if ({sol_raw, sol_enc, res_data} !== '0 || jobs_done !== 16'd0 || b_jobs_done !== 2'd0) begin
            errors++;
            $display("FAIL reset_regs: got raw=%h enc=%h res=%h jobs=%0d/%0d, want 0",
                     sol_raw, sol_enc, res_data, jobs_done, b_jobs_done);
        end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        m_jobs = 0;
        m_ptr  = 1'b0;
    endtask

    task automatic test_single_encrypt();
        logic [ENC_W-1:0] exp;
        enc_data  = 60'h0123456789ABCDE;
        enc_valid = 1'b1;
        exp = model_result(1'b0, enc_data, dec_data);
        serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
        m_jobs++; m_ptr = 1'b1;
        checks++;
        if (!s_ok || s_gd !== 1'b0 || s_lat != LAT + 1) begin
            errors++;
            $display("FAIL enc_timing: got ok=%b dec_grant=%b lat=%0d, want ok=1 dec_grant=0 lat=%0d",
                     s_ok, s_gd, s_lat, LAT + 1);
        end
        checks++;
        if (s_data !== exp || s_dec !== 1'b0 || jobs_done !== 16'd1) begin
            errors++;
            $display("FAIL enc_result: got data=%h dec=%b jobs=%0d, want data=%h dec=0 jobs=1",
                     s_data, s_dec, jobs_done, exp);
        end
        last_cipher = s_data;
    endtask

    task automatic test_single_decrypt();
        dec_data  = last_cipher;
        dec_valid = 1'b1;
        serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
        m_jobs++; m_ptr = 1'b0;
        checks++;
        if (!s_ok || s_gd !== 1'b1 || s_lat != LAT + 1) begin
            errors++;
            $display("FAIL dec_timing: got ok=%b dec_grant=%b lat=%0d, want ok=1 dec_grant=1 lat=%0d",
                     s_ok, s_gd, s_lat, LAT + 1);
        end
        checks++;
        if (s_data !== {18'b0, 60'h0123456789ABCDE} || s_dec !== 1'b1 || jobs_done !== 16'd2) begin
            errors++;
            $display("FAIL dec_roundtrip: got data=%h dec=%b jobs=%0d, want data=%h dec=1 jobs=2",
                     s_data, s_dec, jobs_done, {18'b0, 60'h0123456789ABCDE});
        end
    endtask

    task automatic test_both_valid();
        bit exp_order[3] = '{1'b0, 1'b1, 1'b0};
        logic [ENC_W-1:0] exp;
        apply_reset();
        enc_data  = 60'({$urandom, $urandom});
        dec_data  = 78'({$urandom, $urandom, $urandom});
        enc_valid = 1'b1;
        dec_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin
                enc_data  = 60'({$urandom, $urandom});
                dec_data  = 78'({$urandom, $urandom, $urandom});
                enc_valid = 1'b1;
                dec_valid = 1'b1;
            end
            exp = model_result(exp_order[i], enc_data, dec_data);
            serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
            m_jobs++; m_ptr = !exp_order[i];
            checks++;
            if (!s_ok || s_gd !== exp_order[i] || s_both !== 1'b0 || s_data !== exp || s_dec !== exp_order[i]) begin
                errors++;
                $display("FAIL both_valid[%0d]: got ok=%b dec_grant=%b both_ready=%b data=%h, want dec_grant=%b both_ready=0 data=%h",
                         i, s_ok, s_gd, s_both, s_data, exp_order[i], exp);
            end
        end
        dec_valid = 1'b0;
        enc_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [ENC_W-1:0] exp, held;
        int k;
        res_ready = 1'b0;
        enc_data  = 60'({$urandom, $urandom});
        enc_valid = 1'b1;
        exp = model_result(1'b0, enc_data, dec_data);
        k = 0;
        #1;
        while (!enc_ready && k < 20) begin @(posedge Clk); #2; k++; end
        @(posedge Clk); #1;
        enc_valid = 1'b0;
        dec_data  = 78'({$urandom, $urandom, $urandom});
        dec_valid = 1'b1;
        k = 0;
        while (!res_valid && k < 20) begin @(posedge Clk); #1; k++; end
        held = res_data;
        checks++;
        if (!res_valid || held !== exp) begin
            errors++;
            $display("FAIL bp_first: got valid=%b data=%h, want valid=1 data=%h", res_valid, held, exp);
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge Clk); #1;
            checks++;
            if (res_valid !== 1'b1 || res_data !== held || enc_ready !== 1'b0 || dec_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp_stall[%0d]: got valid=%b data=%h er=%b dr=%b, want valid=1 data=%h er=0 dr=0",
                         c, res_valid, res_data, enc_ready, dec_ready, held);
            end
        end
        res_ready = 1'b1;
        @(posedge Clk); #1;
        m_jobs++; m_ptr = 1'b1;
        checks++;
        if (res_valid !== 1'b0 || jobs_done !== 16'(m_jobs)) begin
            errors++;
            $display("FAIL bp_release: got valid=%b jobs=%0d, want valid=0 jobs=%0d", res_valid, jobs_done, 16'(m_jobs));
        end
        exp = model_result(1'b1, enc_data, dec_data);
        serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
        m_jobs++; m_ptr = 1'b0;
        checks++;
        if (!s_ok || s_gd !== 1'b1 || s_data !== exp || jobs_done !== 16'(m_jobs)) begin
            errors++;
            $display("FAIL bp_pending: got ok=%b dec_grant=%b data=%h jobs=%0d, want dec_grant=1 data=%h jobs=%0d",
                     s_ok, s_gd, s_data, jobs_done, exp, 16'(m_jobs));
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [ENC_W-1:0] exp;
        int k;
        bit seen;
        enc_data  = 60'({$urandom, $urandom});
        enc_valid = 1'b1;
        k = 0;
        #1;
        while (!enc_ready && k < 20) begin @(posedge Clk); #2; k++; end
        @(posedge Clk); #1;
        enc_valid = 1'b0;
        @(posedge Clk); #1;
        checks++;
        if (busy !== 1'b1 || sol_raw !== enc_data) begin
            errors++;
            $display("FAIL rst_pre: got busy=%b raw=%h, want busy=1 raw=%h", busy, sol_raw, enc_data);
        end
        Rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, res_valid} !== 2'b0 || sol_raw !== '0 || res_data !== '0 || jobs_done !== 16'd0) begin
            errors++;
            $display("FAIL rst_mid: got busy=%b valid=%b raw=%h res=%h jobs=%0d, want all 0",
                     busy, res_valid, sol_raw, res_data, jobs_done);
        end
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        m_jobs = 0; m_ptr = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(posedge Clk); #1;
            if (res_valid) seen = 1'b1;
        end
        checks++;
        if (seen || jobs_done !== 16'd0) begin
            errors++;
            $display("FAIL rst_dropped: got result_seen=%b jobs=%0d, want 0 and 0", seen, jobs_done);
        end
        dec_data  = 78'({$urandom, $urandom, $urandom});
        dec_valid = 1'b1;
        exp = model_result(1'b1, enc_data, dec_data);
        serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
        m_jobs++; m_ptr = 1'b0;
        checks++;
        if (!s_ok || s_data !== exp || s_dec !== 1'b1 || s_lat != LAT + 1 || jobs_done !== 16'd1) begin
            errors++;
            $display("FAIL rst_after: got ok=%b data=%h dec=%b lat=%0d jobs=%0d, want data=%h dec=1 lat=%0d jobs=1",
                     s_ok, s_data, s_dec, s_lat, jobs_done, exp, LAT + 1);
        end
    endtask

    task automatic test_random();
        bit pe = 1'b0, pd = 1'b0, exp_dec;
        logic [ENC_W-1:0] exp;
        for (int i = 0; i < 40; i++) begin
            if (!pe && $urandom_range(0, 1) == 1) begin pe = 1'b1; enc_data = 60'({$urandom, $urandom}); end
            if (!pd && $urandom_range(0, 1) == 1) begin pd = 1'b1; dec_data = 78'({$urandom, $urandom, $urandom}); end
            if (!pe && !pd) begin pe = 1'b1; enc_data = 60'({$urandom, $urandom}); end
            enc_valid = pe;
            dec_valid = pd;
            exp_dec = model_pick_dec(m_ptr, pe, pd);
            exp     = model_result(exp_dec, enc_data, dec_data);
            serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
            m_jobs++;
            m_ptr = !exp_dec;
            if (exp_dec) pd = 1'b0;
            else         pe = 1'b0;
            checks++;
            if (!s_ok || s_gd !== exp_dec || s_both !== 1'b0 || s_lat != LAT + 1) begin
                errors++;
                $display("FAIL rand_grant[%0d]: got ok=%b dec_grant=%b both_ready=%b lat=%0d, want dec_grant=%b both_ready=0 lat=%0d",
                         i, s_ok, s_gd, s_both, s_lat, exp_dec, LAT + 1);
                break;
            end
            checks++;
            if (s_data !== exp || s_dec !== exp_dec || jobs_done !== 16'(m_jobs) || b_jobs_done !== 2'(m_jobs)) begin
                errors++;
                $display("FAIL rand_result[%0d]: got data=%h dec=%b jobs=%0d/%0d, want data=%h dec=%b jobs=%0d/%0d",
                         i, s_data, s_dec, jobs_done, b_jobs_done, exp, exp_dec, 16'(m_jobs), 2'(m_jobs));
            end
        end
        enc_valid = 1'b0;
        dec_valid = 1'b0;
    endtask

    task automatic test_counter_wrap();
        int wrap_seq[5] = '{1, 2, 3, 0, 1};
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            enc_data  = 60'({$urandom, $urandom});
            enc_valid = 1'b1;
            serve_one(s_ok, s_gd, s_both, s_lat, s_data, s_dec);
            m_jobs++; m_ptr = 1'b1;
            checks++;
            if (!s_ok || int'(b_jobs_done) != wrap_seq[i] || jobs_done !== 16'(i + 1)) begin
                errors++;
                $display("FAIL wrap[%0d]: got ok=%b jobs_narrow=%0d jobs_wide=%0d, want %0d and %0d",
                         i, s_ok, b_jobs_done, jobs_done, wrap_seq[i], i + 1);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_encrypt();
        test_single_decrypt();
        test_both_valid();
        test_backpressure();
        test_reset_mid_wait();
        test_random();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
